xalu_ise_mc: RTL and testbench

XALU_ISE_MC -- requirements
Module: xalu_ise_mc

---
 rtl/xalu_ise_pkg.sv | 23 ++
 rtl/xalu_mul_step.sv | 25 ++
 rtl/xalu_ise_mc.sv | 181 ++++++++++++++++++
 tb/tb_xalu_ise_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_ise_pkg.sv
// Shared definitions for the multi-cycle multiply/accumulate extension:
// custom opcode classes, funct op encodings and the control state enum.
package xalu_ise_pkg;

    localparam logic [1:0] CUSTOM_0 = 2'b00;
    localparam logic [1:0] CUSTOM_1 = 2'b01;
    localparam logic [1:0] CUSTOM_2 = 2'b10;
    localparam logic [1:0] CUSTOM_3 = 2'b11;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_MAC   = 2'b10,
        OP_ACCSH = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/xalu_mul_step.sv
// One digit-serial multiply step: adds (a * digit idx of b) << (idx*DIGIT)
// into the running 2*XLEN partial product. Purely combinational.
module xalu_mul_step #(
    parameter int XLEN  = 64,
    parameter int DIGIT = 16,
    parameter int IW    = 2
) (
    input  logic [2*XLEN-1:0] pp_in,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [IW-1:0]     idx,
    output logic [2*XLEN-1:0] pp_out
);

    logic [DIGIT-1:0]  digit;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        digit  = b[idx*DIGIT +: DIGIT];
        prod   = (2*XLEN)'(a) * (2*XLEN)'(digit);
        prod   = prod << (idx*DIGIT);
        pp_out = pp_in + prod;
    end

endmodule

// File: rtl/xalu_ise_mc.sv
// Multi-cycle custom-instruction unit: MULLO/MULHI/MAC via a digit-serial
// multiplier, plus a wide accumulator drained XLEN bits at a time by ACCSH.
module xalu_ise_mc
    import xalu_ise_pkg::*;
#(
    parameter int         XLEN  = 64,
    parameter int         DIGIT = 16,
    parameter logic [1:0] ISE_V = 2'b11
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic [4:0]      ise_fn,
    input  logic [6:0]      ise_imm,
    input  logic [XLEN-1:0] ise_in1,
    input  logic [XLEN-1:0] ise_in2,
    input  logic            ise_val,
    output logic            ise_rdy,
    output logic            ise_oval,
    input  logic            ise_ordy,
    output logic [XLEN-1:0] ise_out,
    input  logic            ise_flush,
    output logic [1:0]      ise_state
);

    localparam int NSTEP = XLEN / DIGIT;
    localparam int AW    = 2 * XLEN + 8;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    // Handshakes: a request transfers on the rising edge with ise_val && ise_rdy;
    // a response transfers on the rising edge with ise_oval && ise_ordy, and
    // ise_out/ise_oval hold steady until then unless ise_flush aborts the op.

    state_t              state;
    op_t                 op_q;
    logic                clr_q;
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    logic [2*XLEN-1:0]   pp;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       acc;

    logic                accept;
    logic                supported;
    op_t                 op_in;
    logic                unused;

    logic [XLEN-1:0]     step_a;
    logic [XLEN-1:0]     step_b;
    logic [2*XLEN-1:0]   step_pp;
    logic [CW-1:0]       step_idx;
    op_t                 step_op;
    logic                step_clr;
    logic [2*XLEN-1:0]   pp_next;
    logic                last;
    logic [AW-1:0]       mac_sum;
    logic [AW-1:0]       commit_sum;
    logic [XLEN-1:0]     res;

    assign ise_rdy   = (state == ST_IDLE);
    assign ise_state = state;
    assign accept    = ise_val && ise_rdy;
    assign supported = (ise_fn[1:0] == CUSTOM_1) && ISE_V[1];
    assign op_in     = op_t'(ise_imm[6:5]);
    assign unused    = ^{ise_fn[4:2], ise_imm[4:1]};

    // The first digit is consumed on the accept edge straight from the inputs,
    // so the result lands NSTEP edges after accept.
    always_comb begin
        step_a   = rs1_q;
        step_b   = rs2_q;
        step_pp  = pp;
        step_idx = cnt;
        step_op  = op_q;
        step_clr = clr_q;
        if (state == ST_IDLE) begin
            step_a   = ise_in1;
            step_b   = ise_in2;
            step_pp  = '0;
            step_idx = '0;
            step_op  = op_in;
            step_clr = ise_imm[0];
        end
    end

    xalu_mul_step #(
        .XLEN  (XLEN),
        .DIGIT (DIGIT),
        .IW    (CW)
    ) u_step (
        .pp_in  (step_pp),
        .a      (step_a),
        .b      (step_b),
        .idx    (step_idx),
        .pp_out (pp_next)
    );

    always_comb begin
        last       = (step_idx == CW'(NSTEP - 1));
        mac_sum    = (step_clr ? '0 : acc) + AW'(pp_next);
        commit_sum = (clr_q ? '0 : acc) + AW'(pp);
        case (step_op)
            OP_MULLO: res = pp_next[XLEN-1:0];
            OP_MULHI: res = pp_next[2*XLEN-1:XLEN];
            OP_MAC:   res = mac_sum[XLEN-1:0];
            default:  res = acc[XLEN-1:0];
        endcase
    end

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_MULLO;
            clr_q    <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pp       <= '0;
            cnt      <= '0;
            acc      <= '0;
            ise_oval <= 1'b0;
            ise_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && supported) begin
                        rs1_q <= ise_in1;
                        rs2_q <= ise_in2;
                        op_q  <= op_in;
                        clr_q <= ise_imm[0];
                        if (op_in == OP_ACCSH) begin
                            state    <= ST_DONE;
                            ise_oval <= 1'b1;
                            ise_out  <= acc[XLEN-1:0];
                        end else begin
                            pp <= pp_next;
                            if (last) begin
                                state    <= ST_DONE;
                                ise_oval <= 1'b1;
                                ise_out  <= res;
                            end else begin
                                state <= ST_BUSY;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (ise_flush) begin
                        state <= ST_IDLE;
                        pp    <= '0;
                        cnt   <= '0;
                    end else begin
                        pp <= pp_next;
                        if (last) begin
                            state    <= ST_DONE;
                            cnt      <= '0;
                            ise_oval <= 1'b1;
                            ise_out  <= res;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ise_flush || ise_ordy) begin
                        state    <= ST_IDLE;
                        pp       <= '0;
                        ise_oval <= 1'b0;
                        ise_out  <= '0;
                        // Accumulator only moves when the result is actually taken.
                        if (!ise_flush) begin
                            if (op_q == OP_MAC) acc <= commit_sum;
                            else if (op_q == OP_ACCSH) acc <= acc >> XLEN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu_ise_mc.sv
// Randomised and directed bench for xalu_ise_mc with a queue-based scoreboard
// fed from a wide-integer reference model of the accumulator and multiplies.
module tb_xalu_ise_mc;

    localparam int XLEN  = 64;
    localparam int DIGIT = 16;
    localparam int NSTEP = XLEN / DIGIT;

    localparam logic [1:0] K_MULLO = 2'b00;
    localparam logic [1:0] K_MULHI = 2'b01;
    localparam logic [1:0] K_MAC   = 2'b10;
    localparam logic [1:0] K_ACCSH = 2'b11;

    logic            ise_clk = 1'b0;
    logic            ise_rst;
    logic [4:0]      ise_fn;
    logic [6:0]      ise_imm;
    logic [XLEN-1:0] ise_in1;
    logic [XLEN-1:0] ise_in2;
    logic            ise_val;
    logic            ise_rdy;
    logic            ise_oval;
    logic            ise_ordy;
    logic [XLEN-1:0] ise_out;
    logic            ise_flush;
    logic [1:0]      ise_state;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [2*XLEN+7:0] acc_m;

    xalu_ise_mc #(.XLEN(XLEN), .DIGIT(DIGIT), .ISE_V(2'b11)) dut (
        .ise_clk   (ise_clk),
        .ise_rst   (ise_rst),
        .ise_fn    (ise_fn),
        .ise_imm   (ise_imm),
        .ise_in1   (ise_in1),
        .ise_in2   (ise_in2),
        .ise_val   (ise_val),
        .ise_rdy   (ise_rdy),
        .ise_oval  (ise_oval),
        .ise_ordy  (ise_ordy),
        .ise_out   (ise_out),
        .ise_flush (ise_flush),
        .ise_state (ise_state)
    );

    always #5 ise_clk = ~ise_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-width product and a plain wide integer accumulator.
    function automatic void model(input logic [1:0] op, input logic clr,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] eo, output logic [135:0] na);
        logic [127:0] p;
        logic [135:0] base;
        p  = {64'b0, a} * {64'b0, b};
        na = acc_m;
        case (op)
            K_MULLO: eo = p[63:0];
            K_MULHI: eo = p[127:64];
            K_MAC: begin
                base = clr ? 136'b0 : acc_m;
                na   = base + {8'b0, p};
                eo   = na[63:0];
            end
            default: begin
                eo = acc_m[63:0];
                na = acc_m >> 64;
            end
        endcase
    endfunction

    // Monitor: consume one expected result per response handshake.
    always @(negedge ise_clk) begin
        if (ise_rst) begin
            if (!ise_oval) begin
                check("out_zero_when_invalid", ise_out, 64'h0);
            end else if (ise_ordy && !ise_flush) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h, expected no response", ise_out);
                end else begin
                    check("result", ise_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [4:0] fn, input logic [1:0] op, input logic clr,
                        input logic [63:0] a, input logic [63:0] b, input logic fl);
        check("rdy_before_accept", 64'(ise_rdy), 64'h1);
        ise_fn    = fn;
        ise_imm   = {op, 4'($urandom), clr};
        ise_in1   = a;
        ise_in2   = b;
        ise_val   = 1'b1;
        ise_flush = fl;
        @(posedge ise_clk);
        #1;
        ise_val   = 1'b0;
        ise_flush = 1'b0;
        ise_in1   = {$urandom, $urandom};
        ise_in2   = {$urandom, $urandom};
        ise_imm   = 7'($urandom);
        ise_fn    = 5'($urandom);
    endtask

    task automatic do_op(input logic [1:0] op, input logic clr, input logic [63:0] a,
                         input logic [63:0] b, input int hold, input logic fl);
        logic [63:0]  eo;
        logic [135:0] na;
        int           lat;
        int           exp_lat;
        logic         got;
        model(op, clr, a, b, eo, na);
        exp_lat = (op == K_ACCSH) ? 1 : NSTEP;
        exp_q.push_back(eo);
        send({3'($urandom), 2'b01}, op, clr, a, b, fl);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 16 && !got; k++) begin
            @(negedge ise_clk);
            if (ise_oval) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL oval_timeout: got no ise_oval, expected it after %0d cycles", exp_lat);
            void'(exp_q.pop_back());
            return;
        end
        check("oval_latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge ise_clk);
            #1;
            check("hold_out_stable", ise_out, eo);
            check("hold_oval", 64'(ise_oval), 64'h1);
            check("hold_rdy_low", 64'(ise_rdy), 64'h0);
        end
        @(posedge ise_clk);
        #1;
        ise_ordy = 1'b1;
        @(posedge ise_clk);
        #1;
        ise_ordy = 1'b0;
        check("rdy_after_handshake", 64'(ise_rdy), 64'h1);
        check("oval_after_handshake", 64'(ise_oval), 64'h0);
        acc_m = na;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge ise_clk);
            check(name, 64'(ise_oval), 64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        ise_rst   = 1'b0;
        ise_val   = 1'b0;
        ise_ordy  = 1'b0;
        ise_flush = 1'b0;
        ise_fn    = '0;
        ise_imm   = '0;
        ise_in1   = '0;
        ise_in2   = '0;
        acc_m     = '0;

        #12;
        check("reset_oval", 64'(ise_oval), 64'h0);
        check("reset_out", ise_out, 64'h0);
        check("reset_rdy", 64'(ise_rdy), 64'h1);
        check("reset_state", 64'(ise_state), 64'h0);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        @(posedge ise_clk);
        #1;

        // Boundary multiplies.
        do_op(K_MULLO, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 1'b0);
        do_op(K_MULHI, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 1'b0);

        // Accumulator carry past XLEN and draining.
        do_op(K_MAC,   1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 0, 1'b0);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 0, 1'b0);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 0, 1'b0);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 0, 1'b0);

        // Back-pressure in DONE.
        do_op(K_MULLO, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3, 1'b0);
        do_op(K_MAC,   1'b1, 64'd3, 64'd5, 3, 1'b0);
        do_op(K_MAC,   1'b0, 64'd2, 64'd2, 2, 1'b0);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 3, 1'b0);

        // Flush on the second BUSY cycle of a MAC.
        do_op(K_MAC, 1'b1, 64'd5, 64'd7, 0, 1'b0);
        send(5'b00001, K_MAC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        @(posedge ise_clk);
        #1;
        ise_flush = 1'b1;
        @(posedge ise_clk);
        #1;
        ise_flush = 1'b0;
        check("flush_oval", 64'(ise_oval), 64'h0);
        check("flush_rdy", 64'(ise_rdy), 64'h1);
        check("flush_state", 64'(ise_state), 64'h0);
        expect_quiet("flush_no_oval", 6);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 0, 1'b0);

        // Unsupported opcode class.
        send(5'b00000, K_MAC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        check("unsup_state", 64'(ise_state), 64'h0);
        check("unsup_rdy", 64'(ise_rdy), 64'h1);
        expect_quiet("unsup_no_oval", 8);

        // Random traffic, including flush asserted while idle at accept.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: ra = 64'(1) << $urandom_range(0, 63);
                default: ra = {$urandom, $urandom};
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
            do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), ra, rb,
                  $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        // Reset while BUSY with a nonzero accumulator.
        do_op(K_MAC, 1'b1, {$urandom, $urandom} | 64'h1, {$urandom, $urandom} | 64'h1, 0, 1'b0);
        send(5'b00001, K_MAC, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        @(posedge ise_clk);
        #1;
        ise_rst = 1'b0;
        #1;
        check("rst_busy_oval", 64'(ise_oval), 64'h0);
        check("rst_busy_out", ise_out, 64'h0);
        check("rst_busy_rdy", 64'(ise_rdy), 64'h1);
        @(negedge ise_clk);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        acc_m   = '0;
        expect_quiet("rst_no_oval", 8);
        do_op(K_ACCSH, 1'b0, 64'h0, 64'h0, 0, 1'b0);

        repeat (3) @(posedge ise_clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
